// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308-style ADC scanner:
// config-word bit positions, config-word builder and FSM state encoding.
package adc_pkg;

   localparam int CFG_W = 6;

   localparam int SD  = 5;
   localparam int OS  = 4;
   localparam int S1  = 3;
   localparam int S0  = 2;
   localparam int UNI = 1;
   localparam int SLP = 0;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      XFER,
      LATCH
   } state_e;

   // Single-ended select: OS carries ch[0], S1/S0 carry ch[2:1].
   function automatic logic [CFG_W-1:0] cfg_word(
      input logic [2:0] ch,
      input logic       uni
   );
      logic [CFG_W-1:0] w;
      w      = '0;
      w[SD]  = 1'b1;
      w[OS]  = ch[0];
      w[S1]  = ch[2];
      w[S0]  = ch[1];
      w[UNI] = uni;
      w[SLP] = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: divides clk into SCK with one-cycle edge ticks.
// Ports: clk, reset_n, en_i (run), sck_o, rise_tick_o, fall_tick_o.
module spi_sck_gen #(
   parameter int SCK_HALF = 250
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   output logic sck_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   localparam int CW = $clog2(SCK_HALF);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d;
   logic          wrap;

   // Ticks coincide with the clk edge on which sck_q toggles.
   assign wrap        = en_i && (cnt_q == CW'(SCK_HALF - 1));
   assign rise_tick_o = wrap && !sck_q;
   assign fall_tick_o = wrap && sck_q;
   assign sck_o       = sck_q;

   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (!en_i) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         sck_d = !sck_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

endmodule

// File: rtl/adc_spi_scanner.sv
// Round-robin SPI scanner for an 8-channel SAR ADC (CONVST/SCK/SDI/SDO).
// Ports: start/continuous/unipolar control, ADC pins, per-sample strobe
// (sample_valid/ch/data), per-channel data_flat, busy and scan_done.
module adc_spi_scanner
   import adc_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 12,
   parameter int SCK_HALF    = 250,
   parameter int CONV_CYCLES = 80
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     continuous,
   input  logic                     unipolar,
   output logic                     busy,
   output logic                     adc_convst,
   output logic                     adc_sck,
   output logic                     adc_sdi,
   input  logic                     adc_sdo,
   output logic                     sample_valid,
   output logic [2:0]               sample_ch,
   output logic [DATA_W-1:0]        sample_data,
   output logic [NUM_CH*DATA_W-1:0] data_flat,
   output logic                     scan_done
);

   localparam int CC_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam int BC_W = $clog2(DATA_W + 1);

   state_e                    state_q, state_d;
   logic                      prime_q, prime_d;
   logic [2:0]                cfg_ch_q, cfg_ch_d;
   logic [2:0]                rd_ch_q, rd_ch_d;
   logic [CC_W-1:0]           conv_q, conv_d;
   logic [BC_W-1:0]           bit_q, bit_d;
   logic [CFG_W-1:0]          cfg_q, cfg_d;
   logic                      sdi_q, sdi_d;
   logic [DATA_W-1:0]         rx_q, rx_d;
   logic [DATA_W-1:0]         sdata_q, sdata_d;
   logic [2:0]                sch_q, sch_d;
   logic                      sv_q, sv_d;
   logic                      done_q, done_d;
   logic [NUM_CH*DATA_W-1:0]  flat_q, flat_d;

   logic                      sck;
   logic                      rise;
   logic                      fall;
   logic [CFG_W-1:0]          cfg_new;
   logic [2:0]                ch_next;

   spi_sck_gen #(
      .SCK_HALF (SCK_HALF)
   ) u_sck (
      .clk         (clk),
      .reset_n     (reset_n),
      .en_i        (state_q == XFER),
      .sck_o       (sck),
      .rise_tick_o (rise),
      .fall_tick_o (fall)
   );

   assign cfg_new = cfg_word(cfg_ch_q, unipolar);
   assign ch_next = (cfg_ch_q == 3'(NUM_CH - 1)) ? 3'd0
                                                 : cfg_ch_q + 3'd1;

   always_comb begin
      state_d  = state_q;
      prime_d  = prime_q;
      cfg_ch_d = cfg_ch_q;
      rd_ch_d  = rd_ch_q;
      conv_d   = conv_q;
      bit_d    = bit_q;
      cfg_d    = cfg_q;
      sdi_d    = sdi_q;
      rx_d     = rx_q;
      sdata_d  = sdata_q;
      sch_d    = sch_q;
      flat_d   = flat_q;
      sv_d     = 1'b0;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               prime_d  = 1'b1;
               cfg_ch_d = 3'd0;
               rd_ch_d  = 3'd0;
               conv_d   = '0;
               state_d  = CONV;
            end
         end
         CONV: begin
            if (conv_q == CC_W'(CONV_CYCLES - 1)) begin
               // Config MSB goes out on XFER entry; rest via shifter.
               sdi_d   = cfg_new[SD];
               cfg_d   = {cfg_new[CFG_W-2:0], 1'b0};
               bit_d   = '0;
               rx_d    = '0;
               state_d = XFER;
            end else begin
               conv_d = conv_q + 1'b1;
            end
         end
         XFER: begin
            if (rise) begin
               rx_d  = {rx_q[DATA_W-2:0], adc_sdo};
               bit_d = bit_q + 1'b1;
            end
            if (fall) begin
               if (bit_q == BC_W'(DATA_W)) begin
                  sdi_d   = 1'b0;
                  state_d = LATCH;
                  if (!prime_q) begin
                     sv_d    = 1'b1;
                     done_d  = (rd_ch_q == 3'(NUM_CH - 1));
                     sch_d   = rd_ch_q;
                     sdata_d = rx_q;
                     for (int i = 0; i < NUM_CH; i++) begin
                        if (rd_ch_q == 3'(i)) begin
                           flat_d[i*DATA_W +: DATA_W] = rx_q;
                        end
                     end
                  end
               end else begin
                  sdi_d = cfg_q[SD];
                  cfg_d = {cfg_q[CFG_W-2:0], 1'b0};
               end
            end
         end
         LATCH: begin
            prime_d  = 1'b0;
            rd_ch_d  = cfg_ch_q;
            cfg_ch_d = ch_next;
            conv_d   = '0;
            if (done_q && !continuous) begin
               state_d = IDLE;
            end else begin
               state_d = CONV;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         prime_q  <= 1'b0;
         cfg_ch_q <= 3'd0;
         rd_ch_q  <= 3'd0;
         conv_q   <= '0;
         bit_q    <= '0;
         cfg_q    <= '0;
         sdi_q    <= 1'b0;
         rx_q     <= '0;
         sdata_q  <= '0;
         sch_q    <= 3'd0;
         sv_q     <= 1'b0;
         done_q   <= 1'b0;
         flat_q   <= '0;
      end else begin
         state_q  <= state_d;
         prime_q  <= prime_d;
         cfg_ch_q <= cfg_ch_d;
         rd_ch_q  <= rd_ch_d;
         conv_q   <= conv_d;
         bit_q    <= bit_d;
         cfg_q    <= cfg_d;
         sdi_q    <= sdi_d;
         rx_q     <= rx_d;
         sdata_q  <= sdata_d;
         sch_q    <= sch_d;
         sv_q     <= sv_d;
         done_q   <= done_d;
         flat_q   <= flat_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign adc_convst   = (state_q == CONV);
   assign adc_sck      = sck;
   assign adc_sdi      = sdi_q;
   assign sample_valid = sv_q;
   assign sample_ch    = sch_q;
   assign sample_data  = sdata_q;
   assign data_flat    = flat_q;
   assign scan_done    = done_q;

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Directed bench for adc_spi_scanner with a behavioural pipelined ADC.
// Ports: all DUT ports driven/observed; summary printed at the end.
module tb_adc_spi_scanner;

   localparam int NUM_CH      = 4;
   localparam int DATA_W      = 12;
   localparam int SCK_HALF    = 10;
   localparam int CONV_CYCLES = 80;
   localparam int CLK_NS      = 20;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   logic                     start = 1'b0;
   logic                     continuous = 1'b0;
   logic                     unipolar = 1'b0;
   logic                     adc_sdo = 1'b0;
   logic                     busy;
   logic                     adc_convst;
   logic                     adc_sck;
   logic                     adc_sdi;
   logic                     sample_valid;
   logic [2:0]               sample_ch;
   logic [DATA_W-1:0]        sample_data;
   logic [NUM_CH*DATA_W-1:0] data_flat;
   logic                     scan_done;

   always #(CLK_NS/2) clk = ~clk;

   adc_spi_scanner #(
      .NUM_CH      (NUM_CH),
      .DATA_W      (DATA_W),
      .SCK_HALF    (SCK_HALF),
      .CONV_CYCLES (CONV_CYCLES)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .continuous   (continuous),
      .unipolar     (unipolar),
      .busy         (busy),
      .adc_convst   (adc_convst),
      .adc_sck      (adc_sck),
      .adc_sdi      (adc_sdi),
      .adc_sdo      (adc_sdo),
      .sample_valid (sample_valid),
      .sample_ch    (sample_ch),
      .sample_data  (sample_data),
      .data_flat    (data_flat),
      .scan_done    (scan_done)
   );

   function automatic logic [11:0] adc_val(input int ch);
      case (ch)
         0:       return 12'hA5C;
         1:       return 12'h3C1;
         2:       return 12'h7E2;
         3:       return 12'h1F3;
         default: return 12'h000;
      endcase
   endfunction

   localparam logic [47:0] FLAT_EXP = {12'h1F3, 12'h7E2, 12'h3C1, 12'hA5C};

   int tests = 0;
   int fails = 0;

   // ADC model and pin-timing monitors.
   logic [5:0]  rx_cfg = '0;
   int          rx_n = 0;
   logic        have_cfg = 1'b0;
   logic [5:0]  cfg_hold = '0;
   logic [11:0] conv_data = '0;
   int          frame_id = 0;
   int          frames = 0;
   int          rises = 0;
   int          period_bad = 0;
   int          sdi_bad = 0;
   time         conv_t = 0;
   time         last_rise = 0;
   time         sdi_t = 0;
   logic [5:0]  cfg_log[$];

   always @(adc_sdi) sdi_t = $time;

   always @(posedge adc_sck or posedge adc_convst) begin
      if (adc_convst) begin
         frames++;
         frame_id++;
         conv_t    = $time;
         last_rise = 0;
         conv_data = have_cfg ?
            adc_val(int'({cfg_hold[3], cfg_hold[2], cfg_hold[4]})) : 12'h000;
         have_cfg  = 1'b0;
         rx_n      = 0;
      end else begin
         rises++;
         if (last_rise != 0 &&
             ($time - last_rise) != time'(2*SCK_HALF*CLK_NS))
            period_bad++;
         last_rise = $time;
         if (($time - sdi_t) < time'(SCK_HALF*CLK_NS)) sdi_bad++;
         if (rx_n < 6) begin
            rx_cfg = {rx_cfg[4:0], adc_sdi};
            rx_n++;
            if (rx_n == 6) begin
               cfg_log.push_back(rx_cfg);
               cfg_hold = rx_cfg;
               have_cfg = 1'b1;
            end
         end
      end
   end

   int seen_id = 0;
   int sdo_idx = 0;
   always @(negedge adc_convst or negedge adc_sck) begin
      if (seen_id != frame_id) begin
         seen_id = frame_id;
         sdo_idx = DATA_W - 1;
      end else begin
         sdo_idx--;
      end
      adc_sdo = (sdo_idx >= 0) ? conv_data[sdo_idx] : 1'b0;
   end

   int conv_len = 0;
   int conv_bad = 0;
   always @(negedge adc_convst) begin
      conv_len = int'(($time - conv_t) / CLK_NS);
      if (conv_len != CONV_CYCLES) conv_bad++;
   end

   // Strobe / scan_done log.
   logic [2:0]  st_ch[$];
   logic [11:0] st_data[$];
   logic        st_done[$];
   logic        done_busy[$];
   logic        after_busy[$];
   int          done_frames[$];
   int          done_cnt = 0;
   logic        pend = 1'b0;

   always @(negedge clk) begin
      if (pend) after_busy.push_back(busy);
      pend = 1'b0;
      if (sample_valid) begin
         st_ch.push_back(sample_ch);
         st_data.push_back(sample_data);
         st_done.push_back(scan_done);
      end
      if (scan_done) begin
         done_cnt++;
         done_busy.push_back(busy);
         done_frames.push_back(frames);
         pend = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      check("idle_timeout", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"},   64'(busy), 64'd0);
      check({pfx, "_convst"}, 64'(adc_convst), 64'd0);
      check({pfx, "_sck"},    64'(adc_sck), 64'd0);
      check({pfx, "_sdi"},    64'(adc_sdi), 64'd0);
      check({pfx, "_valid"},  64'(sample_valid), 64'd0);
      check({pfx, "_done"},   64'(scan_done), 64'd0);
      check({pfx, "_ch"},     64'(sample_ch), 64'd0);
      check({pfx, "_data"},   64'(sample_data), 64'd0);
      check({pfx, "_flat"},   64'(data_flat), 64'd0);
   endtask

   initial begin
      #(CLK_NS * 60000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int f0, r0, c0, s0, d0, db0, cb0, pb0, sb0, n;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_zero("rst");
      reset_n = 1'b1;
      @(negedge clk);

      // Single scan, unipolar
      unipolar = 1'b1;
      f0 = frames; r0 = rises; c0 = cfg_log.size(); s0 = st_ch.size();
      d0 = done_cnt; db0 = done_busy.size();
      cb0 = conv_bad; pb0 = period_bad; sb0 = sdi_bad;
      pulse_start();
      wait_idle(4000);
      check("s1_frames", 64'(frames - f0), 64'd5);
      check("s1_cfgs",   64'(cfg_log.size() - c0), 64'd5);
      check("s1_cfg0",   64'(cfg_log[c0]), 64'b100010);
      check("s1_cfg1",   64'(cfg_log[c0+1]), 64'b110010);
      check("s1_cfg4",   64'(cfg_log[c0+4]), 64'b100010);
      check("s1_nstb",   64'(st_ch.size() - s0), 64'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("s1_ch%0d", k),   64'(st_ch[s0+k]), 64'(k));
         check($sformatf("s1_dat%0d", k),  64'(st_data[s0+k]),
               64'(adc_val(k)));
         check($sformatf("s1_done%0d", k), 64'(st_done[s0+k]),
               64'(k == 3));
      end
      check("s1_ndone",    64'(done_cnt - d0), 64'd1);
      check("s1_busy_dn",  64'(done_busy[db0]), 64'd1);
      check("s1_busy_aft", 64'(after_busy[db0]), 64'd0);
      check("s1_flat",     64'(data_flat), 64'(FLAT_EXP));
      check("s1_hold_ch",  64'(sample_ch), 64'd3);

      // Pin timing over that scan
      check("t_conv_bad",  64'(conv_bad - cb0), 64'd0);
      check("t_conv_len",  64'(conv_len), 64'(CONV_CYCLES));
      check("t_rises",     64'(rises - r0), 64'd60);
      check("t_period",    64'(period_bad - pb0), 64'd0);
      check("t_sdi_stab",  64'(sdi_bad - sb0), 64'd0);

      // Continuous mode, bipolar configs
      unipolar = 1'b0;
      continuous = 1'b1;
      f0 = frames; c0 = cfg_log.size(); s0 = st_ch.size();
      d0 = done_cnt; db0 = done_busy.size();
      pulse_start();
      wait_done(d0 + 2, 8000);
      repeat (20) @(negedge clk);
      continuous = 1'b0;
      wait_idle(4000);
      check("c_frames", 64'(frames - f0), 64'd13);
      check("c_ndone",  64'(done_cnt - d0), 64'd3);
      check("c_scan2",  64'(done_frames[db0+1] - done_frames[db0]), 64'd4);
      check("c_scan3",  64'(done_frames[db0+2] - done_frames[db0+1]), 64'd4);
      check("c_nstb",   64'(st_ch.size() - s0), 64'd12);
      for (int k = 0; k < 12; k++) begin
         check($sformatf("c_ch%0d", k),  64'(st_ch[s0+k]), 64'(k % 4));
         check($sformatf("c_dat%0d", k), 64'(st_data[s0+k]),
               64'(adc_val(k % 4)));
      end
      check("c_cfg0", 64'(cfg_log[c0]),   64'b100000);
      check("c_cfg1", 64'(cfg_log[c0+1]), 64'b110000);
      check("c_cfg2", 64'(cfg_log[c0+2]), 64'b100100);
      check("c_cfg3", 64'(cfg_log[c0+3]), 64'b110100);
      check("c_cfg4", 64'(cfg_log[c0+4]), 64'b100000);
      check("c_cfg5", 64'(cfg_log[c0+5]), 64'b110000);
      check("c_busy_aft", 64'(after_busy[db0+2]), 64'd0);

      // start while busy is ignored
      f0 = frames; s0 = st_ch.size(); d0 = done_cnt;
      pulse_start();
      repeat (100) @(negedge clk);
      pulse_start();
      repeat (700) @(negedge clk);
      pulse_start();
      wait_idle(4000);
      check("b_frames", 64'(frames - f0), 64'd5);
      check("b_nstb",   64'(st_ch.size() - s0), 64'd4);
      check("b_ndone",  64'(done_cnt - d0), 64'd1);

      // Reset mid-XFER
      unipolar = 1'b1;
      f0 = frames;
      pulse_start();
      n = 0;
      while ((frames - f0) < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (adc_convst && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (60) @(negedge clk);
      check("r_pre_busy", 64'(busy), 64'd1);
      check("r_pre_flat", 64'(data_flat), 64'(FLAT_EXP));
      #3 reset_n = 1'b0;
      #2 check_zero("rmid");
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      f0 = frames; s0 = st_ch.size(); d0 = done_cnt;
      pulse_start();
      wait_idle(4000);
      check("r_frames", 64'(frames - f0), 64'd5);
      check("r_nstb",   64'(st_ch.size() - s0), 64'd4);
      check("r_ndone",  64'(done_cnt - d0), 64'd1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("r_ch%0d", k), 64'(st_ch[s0+k]), 64'(k));
      end
      check("r_flat", 64'(data_flat), 64'(FLAT_EXP));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
